// File: rtl/veritune_pkg.sv
// Shared Veritune constants: default sample/RAM sizing (also used by the FFT stage)
// and the one-hot encodings of the recorder controller states.
package veritune_pkg;

    localparam int VT_DATA_W = 16;
    localparam int VT_ADDR_W = 17;

    localparam logic [3:0] VT_I    = 4'b0001;
    localparam logic [3:0] VT_REC  = 4'b0010;
    localparam logic [3:0] VT_STOP = 4'b0100;
    localparam logic [3:0] VT_PLAY = 4'b1000;

    typedef enum logic [3:0] {
        ST_I    = VT_I,
        ST_REC  = VT_REC,
        ST_STOP = VT_STOP,
        ST_PLAY = VT_PLAY
    } vt_state_e;

endpackage

// File: rtl/vt_sample_ram.sv
// Single-port synchronous sample RAM, 1-cycle registered read, no reset on contents.
module vt_sample_ram
    import veritune_pkg::*;
#(
    parameter int DATA_W = VT_DATA_W,
    parameter int ADDR_W = VT_ADDR_W
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge Clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end else begin
            rdata <= r_mem[addr];
        end
    end

endmodule

// File: rtl/veritune_recorder.sv
// Record/stop/play controller around a single-port sample RAM.
// Optional VT_LOOP_PLAY_EN adds a Loop input for continuous looped playback.
module veritune_recorder
    import veritune_pkg::*;
#(
    parameter int DATA_W = VT_DATA_W,
    parameter int ADDR_W = VT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Rec,
    input  logic              Stop,
    input  logic              Play,
    input  logic              Sample_Tick,
`ifdef VT_LOOP_PLAY_EN
    input  logic              Loop,
`endif
    input  logic [DATA_W-1:0] Audio_In,
    output logic [DATA_W-1:0] Audio_Out,
    output logic              Out_Valid,
    output logic [ADDR_W:0]   Length,
    output logic              Full,
    output logic              q_I,
    output logic              q_Rec,
    output logic              q_Stop,
    output logic              q_Play
);

    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    vt_state_e         r_state;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W:0]   r_length;
    logic              r_full;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_hold;

    vt_state_e         w_state_nxt;
    logic [ADDR_W-1:0] w_index_nxt;
    logic [ADDR_W:0]   w_length_nxt;
    logic              w_full_nxt;
    logic              w_we;
    logic              w_rd;
    logic              w_loop;
    logic              w_last_rec;
    logic              w_last_play;
    logic [DATA_W-1:0] w_rdata;

`ifdef VT_LOOP_PLAY_EN
    assign w_loop = Loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_last_rec  = (r_index == {ADDR_W{1'b1}});
    assign w_last_play = ({1'b0, r_index} == (r_length - 1'b1));

    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_length_nxt = r_length;
        w_full_nxt   = r_full;
        w_we         = 1'b0;
        w_rd         = 1'b0;
        case (r_state)
            ST_I: begin
                if (Rec) begin
                    w_state_nxt = ST_REC;
                    w_index_nxt = '0;
                    w_full_nxt  = 1'b0;
                end
            end
            ST_REC: begin
                // Stop wins over a coincident tick: that sample is dropped.
                if (Stop) begin
                    w_state_nxt  = ST_STOP;
                    w_length_nxt = {1'b0, r_index};
                end else if (Sample_Tick) begin
                    w_we        = 1'b1;
                    w_index_nxt = r_index + 1'b1;
                    if (w_last_rec) begin
                        w_state_nxt  = ST_STOP;
                        w_length_nxt = DEPTH_L;
                        w_full_nxt   = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (Rec) begin
                    w_state_nxt = ST_REC;
                    w_index_nxt = '0;
                    w_full_nxt  = 1'b0;
                end else if (Play && (r_length != '0)) begin
                    w_state_nxt = ST_PLAY;
                    w_index_nxt = '0;
                end
            end
            ST_PLAY: begin
                if (Stop) begin
                    w_state_nxt = ST_STOP;
                end else if (Sample_Tick) begin
                    w_rd        = 1'b1;
                    w_index_nxt = r_index + 1'b1;
                    if (w_last_play) begin
                        w_index_nxt = '0;
                        if (!w_loop) begin
                            w_state_nxt = ST_STOP;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_I;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_I;
            r_index     <= '0;
            r_length    <= '0;
            r_full      <= 1'b0;
            r_out_valid <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_length    <= w_length_nxt;
            r_full      <= w_full_nxt;
            r_out_valid <= w_rd;
            if (r_out_valid) begin
                r_hold <= w_rdata;
            end
        end
    end

    vt_sample_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .Clk  (Clk),
        .we   (w_we),
        .addr (r_index),
        .wdata(Audio_In),
        .rdata(w_rdata)
    );

    // The RAM read register is the output register during the valid cycle;
    // r_hold keeps the last sample between pulses and gives the reset value.
    assign Audio_Out = r_out_valid ? w_rdata : r_hold;
    assign Out_Valid = r_out_valid;
    assign Length    = r_length;
    assign Full      = r_full;
    assign q_I       = r_state[0];
    assign q_Rec     = r_state[1];
    assign q_Stop    = r_state[2];
    assign q_Play    = r_state[3];

endmodule
